// File: rtl/tx_dphy_pkg.sv
// tx_dphy_pkg: shared state encodings, SYNC byte and default timing for the D-PHY TX lane
package tx_dphy_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_REQ, S_ZERO, S_SYNC, S_PAY, S_TRAIL, S_EXIT
  } tx_state_t;
  typedef enum logic [1:0] {
    LP_STOP = 2'd0, LP_HS_REQ = 2'd1, LP_HS_PRPR = 2'd2, LP_HS_WAIT = 2'd3
  } lp_state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hB8;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_LEN_W = 16;
  localparam int DEF_T_HS_ZERO = 6;
  localparam int DEF_T_HS_TRAIL = 4;
  localparam int DEF_T_LP_EXIT = 8;
  localparam int DEF_T_TIMEOUT = 32;
  // Trail drives the line opposite to the last bit transmitted.
  function automatic logic [7:0] trail_byte(input logic last_b7);
    return last_b7 ? 8'h00 : 8'hFF;
  endfunction
endpackage

// File: rtl/tx_rr_arbiter.sv
// tx_rr_arbiter: round-robin search from the slot after the last winner; pointer moves on adv
module tx_rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             adv,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             vld
);
  logic [IW-1:0] ptr;
  // Walk from farthest to nearest so the slot closest to ptr is written last and wins.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N_REQ]) begin
        idx = IW'((int'(ptr) + k) % N_REQ);
        vld = 1'b1;
      end
    end
    gnt = vld ? N_REQ'(1) << idx : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (adv && vld) ptr <= (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
endmodule

// File: rtl/tx_hs_burst_ctrl.sv
// tx_hs_burst_ctrl: HS burst sequencer for one D-PHY TX data lane (arbitration, ZERO/SYNC/payload/TRAIL, LP exit).
// Optional TXC_TIMEOUT_EN: abort a REQ that never sees TX_HS_EN and pulse ERR.
module tx_hs_burst_ctrl
  import tx_dphy_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int T_HS_ZERO  = DEF_T_HS_ZERO,
  parameter int T_HS_TRAIL = DEF_T_HS_TRAIL,
  parameter int T_LP_EXIT  = DEF_T_LP_EXIT,
  parameter int T_TIMEOUT  = DEF_T_TIMEOUT
) (
  input  logic                   TX_BYTE_clk,
  input  logic                   TX_rst_n,
  input  logic [N_REQ-1:0]       REQ_VEC,
  input  logic [N_REQ*LEN_W-1:0] LEN_VEC,
  input  logic [N_REQ*8-1:0]     DATA_VEC,
  output logic [N_REQ-1:0]       GNT,
  output logic [N_REQ-1:0]       DATA_ACK,
  output logic                   TX_REQ,
  input  logic                   TX_HS_EN,
  input  logic                   TX_HS_END_DATA,
  output logic [7:0]             HS_DATA,
  output logic                   HS_DATA_VLD,
  output logic                   BUSY,
  output logic                   ERR
);
  localparam int IW = $clog2(N_REQ);
  tx_state_t state, state_nx;
  logic [N_REQ-1:0] a_gnt, win_oh;
  logic [IW-1:0] a_idx, win_idx;
  logic a_vld, in_burst, hs_fault, tmo, ended, last_b7;
  logic [LEN_W-1:0] len, cnt, cnt_nx;

  tx_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk(TX_BYTE_clk), .rst_n(TX_rst_n), .req(REQ_VEC), .adv(state == S_ARB),
    .gnt(a_gnt), .idx(a_idx), .vld(a_vld)
  );

`ifdef TXC_TIMEOUT_EN
  localparam int TW = $clog2(T_TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic err_q;
  assign tmo = (state == S_REQ) && !TX_HS_EN && (tcnt == TW'(T_TIMEOUT - 1));
  assign ERR = err_q;
  always_ff @(posedge TX_BYTE_clk or negedge TX_rst_n)
    if (!TX_rst_n) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      tcnt  <= (state == S_REQ) ? tcnt + 1'b1 : '0;
      err_q <= tmo;
    end
`else
  assign tmo = 1'b0;
  assign ERR = 1'b0;
`endif

  assign in_burst = state inside {S_ZERO, S_SYNC, S_PAY, S_TRAIL};
  assign hs_fault = in_burst && !TX_HS_EN;

  always_ff @(posedge TX_BYTE_clk or negedge TX_rst_n)
    if (!TX_rst_n) state <= S_IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = |REQ_VEC ? S_ARB : S_IDLE;
      S_ARB:   state_nx = a_vld ? S_REQ : S_IDLE;
      S_REQ:   state_nx = TX_HS_EN ? S_ZERO : tmo ? S_EXIT : S_REQ;
      S_ZERO:  state_nx = (cnt == '0) ? S_SYNC : S_ZERO;
      S_SYNC:  state_nx = (len != '0) ? S_PAY : S_TRAIL;
      S_PAY:   state_nx = (cnt == '0) ? S_TRAIL : S_PAY;
      S_TRAIL: state_nx = (cnt == '0) ? S_EXIT : S_TRAIL;
      S_EXIT:  state_nx = (ended && cnt == '0) ? S_IDLE : S_EXIT;
      default: state_nx = S_IDLE;
    endcase
    if (hs_fault) state_nx = S_EXIT;
  end

  // One down-counter serves every timed phase; it is reloaded on each state change.
  always_comb begin
    cnt_nx = (cnt != '0) ? cnt - 1'b1 : cnt;
    if (state_nx != state)
      cnt_nx = (state_nx == S_ZERO)  ? LEN_W'(T_HS_ZERO - 1) :
               (state_nx == S_PAY)   ? len - 1'b1 :
               (state_nx == S_TRAIL) ? LEN_W'(T_HS_TRAIL - 1) : '0;
    if (state == S_EXIT && !ended) cnt_nx = LEN_W'(T_LP_EXIT - 1);
  end

  always_ff @(posedge TX_BYTE_clk or negedge TX_rst_n)
    if (!TX_rst_n) begin
      win_idx <= '0;
      win_oh  <= '0;
      len     <= '0;
      cnt     <= '0;
      ended   <= 1'b0;
      last_b7 <= 1'b0;
    end else begin
      if (state == S_ARB && a_vld) begin
        win_idx <= a_idx;
        win_oh  <= a_gnt;
        len     <= LEN_VEC[int'(a_idx)*LEN_W +: LEN_W];
      end
      if (state == S_SYNC || state == S_PAY) last_b7 <= HS_DATA[7];
      ended <= (state == S_EXIT) && (ended || TX_HS_END_DATA);
      cnt   <= cnt_nx;
    end

  always_comb begin
    TX_REQ      = in_burst || state == S_REQ;
    GNT         = TX_REQ ? win_oh : '0;
    DATA_ACK    = (state == S_PAY) ? win_oh : '0;
    HS_DATA_VLD = in_burst;
    BUSY        = state != S_IDLE;
    HS_DATA     = (state == S_SYNC)  ? SYNC_BYTE :
                  (state == S_PAY)   ? DATA_VEC[int'(win_idx)*8 +: 8] :
                  (state == S_TRAIL) ? trail_byte(last_b7) : 8'h00;
  end
endmodule
